// File: rtl/mem_pkg.sv
// Shared constants, state type and byte-lane helper for the MEM-stage access block.
package mem_pkg;

    localparam int unsigned ADDR_W_DEF = 8;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;
    localparam logic RW_READ   = 1'b0;
    localparam logic RW_WRITE  = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Big-endian lane select: index 0 is the most significant byte.
    function automatic logic [7:0] get_byte(input logic [31:0] i_word, input logic [1:0] i_idx);
        logic [7:0] w_b;
        case (i_idx)
            2'd0:    w_b = i_word[31:24];
            2'd1:    w_b = i_word[23:16];
            2'd2:    w_b = i_word[15:8];
            default: w_b = i_word[7:0];
        endcase
        return w_b;
    endfunction

endpackage

// File: rtl/byte_ram.sv
// Single-port byte-wide data RAM: synchronous write, asynchronous read.
module byte_ram #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_wdata,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage_access.sv
// MEM pipeline stage: byte/word loads and stores through a byte RAM, plus the MEM/WB register.
module mem_stage_access
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              R,
    input  logic              MEM_load_instr,
    input  logic              MEM_RF_enable,
    input  logic              MEM_Size_enable,
    input  logic              MEM_RW_enable,
    input  logic              MEM_Enable_signal,
    input  logic [DATA_W-1:0] MEM_addr,
    input  logic [DATA_W-1:0] MEM_store_data,
    input  logic [DATA_W-1:0] MEM_alu_out,
    input  logic [3:0]        MEM_Rd,
    output logic              stall,
    output logic [DATA_W-1:0] WB_data,
    output logic              WB_RF_enable,
    output logic [3:0]        WB_Rd,
    output logic              WB_load_instr
);

    state_e              r_state, w_state_next;
    logic [1:0]          r_beat, w_beat_next;
    logic [ADDR_W-3:0]   r_base;
    logic [DATA_W-1:0]   r_wdata;
    logic [3:0]          r_rd;
    logic                r_rf_en;
    logic                r_load;
    logic                r_rw;
    logic [23:0]         r_asm;

    logic                w_is_word;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic                w_ram_we;
    logic [7:0]          w_ram_wdata;
    logic [7:0]          w_ram_rdata;
    logic                w_unused;

    assign w_unused  = ^MEM_addr[DATA_W-1:ADDR_W];
    assign w_is_word = (r_state == IDLE) && MEM_Enable_signal && (MEM_Size_enable == SIZE_WORD);

    always_comb begin
        w_state_next = r_state;
        w_beat_next  = r_beat;
        w_ram_addr   = MEM_addr[ADDR_W-1:0];
        w_ram_we     = 1'b0;
        w_ram_wdata  = MEM_store_data[7:0];
        stall        = 1'b0;
        // Reset wins over any access in flight: no stall and no RAM write this cycle.
        if (R) begin
            w_state_next = IDLE;
            w_beat_next  = 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (MEM_Enable_signal) begin
                        w_ram_we = (MEM_RW_enable == RW_WRITE);
                        if (MEM_Size_enable == SIZE_WORD) begin
                            w_ram_addr   = {MEM_addr[ADDR_W-1:2], 2'b00};
                            w_ram_wdata  = MEM_store_data[31:24];
                            stall        = 1'b1;
                            w_state_next = BUSY;
                            w_beat_next  = 2'd1;
                        end
                    end
                end
                BUSY: begin
                    w_ram_addr  = {r_base, r_beat};
                    w_ram_we    = r_rw;
                    w_ram_wdata = get_byte(r_wdata, r_beat);
                    stall       = (r_beat != 2'd3);
                    w_beat_next = r_beat + 2'd1;
                    if (r_beat == 2'd3) begin
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (R) begin
            r_state       <= IDLE;
            r_beat        <= 2'd0;
            WB_data       <= '0;
            WB_RF_enable  <= 1'b0;
            WB_Rd         <= 4'd0;
            WB_load_instr <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_beat  <= w_beat_next;
            if (stall) begin
                WB_RF_enable  <= 1'b0;
                WB_load_instr <= 1'b0;
            end
            if (r_state == IDLE) begin
                if (!w_is_word) begin
                    WB_RF_enable  <= MEM_RF_enable;
                    WB_Rd         <= MEM_Rd;
                    WB_load_instr <= MEM_Enable_signal & MEM_load_instr;
                    if (!MEM_Enable_signal) begin
                        WB_data <= MEM_alu_out;
                    end else if (MEM_RW_enable == RW_READ) begin
                        WB_data <= {24'b0, w_ram_rdata};
                    end
                end
            end else if (r_beat == 2'd3) begin
                if (r_rw == RW_READ) begin
                    WB_data <= {r_asm, w_ram_rdata};
                end
                WB_RF_enable  <= r_rf_en;
                WB_Rd         <= r_rd;
                WB_load_instr <= r_load;
            end
        end
    end

    // Captured operands and partially assembled load word; need no reset.
    always_ff @(posedge clk) begin
        if (w_is_word) begin
            r_base        <= MEM_addr[ADDR_W-1:2];
            r_wdata       <= MEM_store_data;
            r_rd          <= MEM_Rd;
            r_rf_en       <= MEM_RF_enable;
            r_load        <= MEM_load_instr;
            r_rw          <= MEM_RW_enable;
            r_asm[23:16]  <= w_ram_rdata;
        end else if (r_state == BUSY) begin
            if (r_beat == 2'd1) begin
                r_asm[15:8] <= w_ram_rdata;
            end else if (r_beat == 2'd2) begin
                r_asm[7:0] <= w_ram_rdata;
            end
        end
    end

    byte_ram #(
        .ADDR_W (ADDR_W)
    ) u_byte_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed self-checking bench for mem_stage_access.
module tb_mem_stage_access;

    logic        clk = 1'b0;
    logic        R;
    logic        MEM_load_instr, MEM_RF_enable, MEM_Size_enable, MEM_RW_enable, MEM_Enable_signal;
    logic [31:0] MEM_addr, MEM_store_data, MEM_alu_out;
    logic [3:0]  MEM_Rd;
    logic        stall;
    logic [31:0] WB_data;
    logic        WB_RF_enable;
    logic [3:0]  WB_Rd;
    logic        WB_load_instr;

    int checks   = 0;
    int failures = 0;

    mem_stage_access dut (
        .clk               (clk),
        .R                 (R),
        .MEM_load_instr    (MEM_load_instr),
        .MEM_RF_enable     (MEM_RF_enable),
        .MEM_Size_enable   (MEM_Size_enable),
        .MEM_RW_enable     (MEM_RW_enable),
        .MEM_Enable_signal (MEM_Enable_signal),
        .MEM_addr          (MEM_addr),
        .MEM_store_data    (MEM_store_data),
        .MEM_alu_out       (MEM_alu_out),
        .MEM_Rd            (MEM_Rd),
        .stall             (stall),
        .WB_data           (WB_data),
        .WB_RF_enable      (WB_RF_enable),
        .WB_Rd             (WB_Rd),
        .WB_load_instr     (WB_load_instr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic sz, input logic rw, input logic ld,
                         input logic rf, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] alu, input logic [3:0] rd);
        MEM_Enable_signal = en;
        MEM_Size_enable   = sz;
        MEM_RW_enable     = rw;
        MEM_load_instr    = ld;
        MEM_RF_enable     = rf;
        MEM_addr          = addr;
        MEM_store_data    = sd;
        MEM_alu_out       = alu;
        MEM_Rd            = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic word_op(input string tag, input logic rw, input logic ld, input logic rf,
                           input logic [31:0] addr, input logic [31:0] sd, input logic [3:0] rd,
                           input logic [31:0] exp_data, input bit check_data);
        drive(1'b1, 1'b1, rw, ld, rf, addr, sd, 32'h0, rd);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk({tag, "_stall"}, {31'b0, stall}, {31'b0, (k < 3)});
            step();
            if (k < 3) chk({tag, "_bubble_rf"}, {31'b0, WB_RF_enable}, 32'd0);
        end
        chk({tag, "_rd"}, {28'b0, WB_Rd}, {28'b0, rd});
        chk({tag, "_rf"}, {31'b0, WB_RF_enable}, {31'b0, rf});
        chk({tag, "_ld"}, {31'b0, WB_load_instr}, {31'b0, ld});
        if (check_data) chk({tag, "_data"}, WB_data, exp_data);
    endtask

    task automatic byte_op(input string tag, input logic rw, input logic ld,
                           input logic [31:0] addr, input logic [31:0] sd,
                           input logic [31:0] exp_data, input bit check_data);
        drive(1'b1, 1'b0, rw, ld, 1'b1, addr, sd, 32'h0, 4'd2);
        @(negedge clk);
        chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
        step();
        chk({tag, "_ld"}, {31'b0, WB_load_instr}, {31'b0, ld});
        if (check_data) chk({tag, "_data"}, WB_data, exp_data);
    endtask

    task automatic alu_op(input string tag, input logic [31:0] alu, input logic [3:0] rd);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, alu, rd);
        @(negedge clk);
        chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
        step();
        chk({tag, "_data"}, WB_data, alu);
        chk({tag, "_rd"}, {28'b0, WB_Rd}, {28'b0, rd});
        chk({tag, "_rf"}, {31'b0, WB_RF_enable}, 32'd1);
        chk({tag, "_ld"}, {31'b0, WB_load_instr}, 32'd0);
    endtask

    initial begin
        // Power-up reset with a word request presented: stall must stay low.
        R = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 32'h0, 4'd1);
        step();
        #1 chk("rst_stall", {31'b0, stall}, 32'd0);
        step();
        chk("rst_wb_data", WB_data, 32'd0);
        chk("rst_wb_rf", {31'b0, WB_RF_enable}, 32'd0);
        chk("rst_wb_rd", {28'b0, WB_Rd}, 32'd0);
        chk("rst_wb_ld", {31'b0, WB_load_instr}, 32'd0);
        R = 1'b0;

        alu_op("alu1", 32'hDEADBEEF, 4'd5);

        word_op("wst20", 1'b1, 1'b0, 1'b0, 32'h20, 32'h11223344, 4'd0, 32'h0, 1'b0);
        word_op("wld22", 1'b0, 1'b1, 1'b1, 32'h22, 32'h0, 4'd7, 32'h11223344, 1'b1);
        byte_op("bld20", 1'b0, 1'b1, 32'h20, 32'h0, 32'h00000011, 1'b1);
        byte_op("bld23", 1'b0, 1'b1, 32'h23, 32'h0, 32'h00000044, 1'b1);

        byte_op("bst07", 1'b1, 1'b0, 32'h07, 32'hFFFFFFA5, 32'h0, 1'b0);
        byte_op("bld07", 1'b0, 1'b1, 32'h07, 32'h0, 32'h000000A5, 1'b1);

        word_op("wstFC", 1'b1, 1'b0, 1'b1, 32'hFC, 32'hA1B2C3D4, 4'd6, 32'h0, 1'b0);
        word_op("wldFD", 1'b0, 1'b1, 1'b1, 32'h1FD, 32'h0, 4'd8, 32'hA1B2C3D4, 1'b1);
        alu_op("alu_after_wrap", 32'h0BADF00D, 4'd10);

        // Reset in the middle of a word store: first two bytes land, last two keep old data.
        word_op("wst10", 1'b1, 1'b0, 1'b0, 32'h10, 32'hCAFEF00D, 4'd0, 32'h0, 1'b0);
        alu_op("alu_pre_rst", 32'h12345678, 4'd9);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h01020304, 32'h0, 4'd3);
        step();
        step();
        R = 1'b1;
        #1 chk("midrst_stall", {31'b0, stall}, 32'd0);
        step();
        step();
        chk("midrst_wb_data", WB_data, 32'd0);
        chk("midrst_wb_rf", {31'b0, WB_RF_enable}, 32'd0);
        chk("midrst_wb_rd", {28'b0, WB_Rd}, 32'd0);
        chk("midrst_wb_ld", {31'b0, WB_load_instr}, 32'd0);
        R = 1'b0;
        byte_op("rst_b10", 1'b0, 1'b1, 32'h10, 32'h0, 32'h00000001, 1'b1);
        byte_op("rst_b11", 1'b0, 1'b1, 32'h11, 32'h0, 32'h00000002, 1'b1);
        byte_op("rst_b12", 1'b0, 1'b1, 32'h12, 32'h0, 32'h000000F0, 1'b1);
        byte_op("rst_b13", 1'b0, 1'b1, 32'h13, 32'h0, 32'h0000000D, 1'b1);

        // Word load followed by an ALU op that is presented while the load stalls.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h21, 32'h0, 32'h0, 4'd3);
        @(negedge clk);
        chk("b2b_stall0", {31'b0, stall}, 32'd1);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h55AA55AA, 4'd4);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("b2b_stall", {31'b0, stall}, {31'b0, (k < 3)});
            step();
            if (k < 3) chk("b2b_bubble_rf", {31'b0, WB_RF_enable}, 32'd0);
        end
        chk("b2b_ld_data", WB_data, 32'h11223344);
        chk("b2b_ld_rd", {28'b0, WB_Rd}, 32'd3);
        chk("b2b_ld_flag", {31'b0, WB_load_instr}, 32'd1);
        chk("b2b_ld_rf", {31'b0, WB_RF_enable}, 32'd1);
        @(negedge clk);
        chk("b2b_alu_stall", {31'b0, stall}, 32'd0);
        step();
        chk("b2b_alu_data", WB_data, 32'h55AA55AA);
        chk("b2b_alu_rd", {28'b0, WB_Rd}, 32'd4);
        chk("b2b_alu_ld", {31'b0, WB_load_instr}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'd0);
        step();
        chk("b2b_no_dup_rf", {31'b0, WB_RF_enable}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_access.md
Name: mem_stage_access

Overview:
- MEM-stage block directly downstream of the EX/MEM pipeline latch.
- Consumes the latched MEM_* control signals plus address, store data, ALU result and destination register.
- Performs data-memory loads and stores against an internal byte-wide RAM and registers the MEM/WB pipeline outputs.
- Word accesses take four byte beats through the single 8-bit RAM port; the block stalls upstream stages meanwhile.

Parameters:
- ADDR_W, 8, byte-address width of internal RAM (depth = 2**ADDR_W bytes)
- DATA_W, 32, datapath width; fixed at 32 (four beats per word)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- R  in  1  reset, synchronous, active-high
- MEM_load_instr  in  1  1 = load, valid only with MEM_Enable_signal
- MEM_RF_enable  in  1  instruction writes the register file
- MEM_Size_enable  in  1  access size: 0 = byte, 1 = word
- MEM_RW_enable  in  1  0 = read, 1 = write
- MEM_Enable_signal  in  1  memory access requested this cycle
- MEM_addr  in  32  byte address; only [ADDR_W-1:0] used
- MEM_store_data  in  32  store operand (byte stores use [7:0])
- MEM_alu_out  in  32  ALU result for non-load instructions
- MEM_Rd  in  4  destination register
- stall  out  1  hold EX/MEM and upstream stages this cycle
- WB_data  out  32  write-back value
- WB_RF_enable  out  1  register-file write enable into WB
- WB_Rd  out  4  write-back destination
- WB_load_instr  out  1  write-back came from a load

Behaviour:
- Reset: R high at a clock edge sets state IDLE, beat = 0, WB_data = 0, WB_RF_enable = 0, WB_Rd = 0, WB_load_instr = 0. The stall output is 0 while R is high. RAM contents are not reset.
- Reset mid-word: R aborts the access. Bytes already written stay written (stores are non-atomic). No WB result is produced.
- Byte order: big-endian. A word at base A has byte A on [31:24], A+1 on [23:16], A+2 on [15:8], A+3 on [7:0].
- Word alignment: the word base is MEM_addr with [1:0] forced to 0.
- States: IDLE and BUSY, plus a 2-bit beat counter.
- Non-memory instruction (MEM_Enable_signal = 0), in IDLE:
  - 1-cycle latency; no stall.
  - Next edge: WB_data = MEM_alu_out, WB_RF_enable = MEM_RF_enable, WB_Rd = MEM_Rd, WB_load_instr = 0.
- Byte access (Enable = 1, Size = 0), in IDLE, single cycle, no stall:
  - Write: RAM[addr] <= store_data[7:0] at the edge.
  - Read: WB_data = {24'b0, RAM[addr]} (zero-extended), registered at the edge.
  - WB_RF_enable = MEM_RF_enable, WB_load_instr = MEM_load_instr.
  - A byte store followed by a byte load of the same address on the next cycle returns the new value.
- Word access (Enable = 1, Size = 1), in IDLE, takes 4 cycles total:
  - Cycle 0 is the accept cycle: stall = 1 combinationally. Base, store data, Rd, RF_enable and load flag are captured. Beat 0 is transferred. Next state is BUSY with beat = 1.
  - In BUSY, beat k transfers byte base+k. stall = 1 for beats 1 and 2, and 0 for beat 3.
  - At the beat-3 edge, WB outputs load the assembled word (reads) or WB_RF_enable = captured RF_enable (writes), WB_load_instr = captured load flag, WB_Rd = captured Rd. State returns to IDLE.
  - Upstream presents the next instruction in the cycle after beat 3.
- Bubbles: at every edge where stall = 1, WB_RF_enable <= 0 and WB_load_instr <= 0 (bubble into WB).
- Input stability: in BUSY, inputs are ignored; only the captured values are used.
- RAM port: at most one RAM byte write per cycle.
- RAM address wraps modulo 2**ADDR_W (base+k never crosses the aligned word).
- Invalid combination: MEM_RW_enable = 1 with MEM_load_instr = 1 is treated as a write; the load flag is still propagated.

Decomposition:
- Shared package mem_pkg: ADDR_W default, SIZE_BYTE/SIZE_WORD and RW_READ/RW_WRITE constants, state enum {IDLE, BUSY}.
- Sub-module byte_ram: single-port 8-bit RAM.
  - Synchronous write.
  - Asynchronous read, so the load byte is available in the same beat.
- FSM, beat counter, word assembly and WB register live in mem_stage_access.

Test Plan:
1. R = 1 for 2 cycles mid-word-store to 0x10 (after beat 1) -> all WB_* = 0, stall = 0, state IDLE; RAM[0x10..0x11] written, RAM[0x12..0x13] unchanged.
2. ALU op, alu_out = 0xDEADBEEF, Rd = 5, RF_enable = 1 -> next cycle WB_data = 0xDEADBEEF, WB_Rd = 5, WB_RF_enable = 1, stall never asserted.
3. Word store 0x11223344 to 0x20, then word load from 0x22 -> stall high for 3 cycles each; load WB_data = 0x11223344 (alignment); RAM[0x20] = 0x11, RAM[0x23] = 0x44; WB_RF_enable = 0 during stall edges.
4. Byte store 0xA5 to 0x07, next cycle byte load 0x07 -> WB_data = 0x000000A5, WB_load_instr = 1, no stall.
5. Word load at 0xFC with ADDR_W = 8 -> bytes 0xFC..0xFF assembled; beat counter wraps to 0 and state returns to IDLE after exactly 4 cycles.
6. Back-to-back: word load then ALU op held during stall -> ALU result appears in WB exactly 1 cycle after the load's WB result, with no duplicate or lost write-back.
